// File: rtl/sensor_conditioner.sv
// Input conditioning for the irrigation operation FSM: synchronises and debounces
// the raw field-sensor lines and keeps the time-of-day counter with its day-window flag.
module sensor_conditioner #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned TICKS_PER_HOUR = 10,
    parameter int unsigned H_START        = 6,
    parameter int unsigned H_END          = 18
) (
    input  logic       Ck,
    input  logic       Clr,
    input  logic       En,
    input  logic       Load,
    input  logic [4:0] HourIn,
    input  logic       S5_raw,
    input  logic       S6_raw,
    input  logic       S7_raw,
    output logic       I5,
    output logic       I6,
    output logic       I7,
    output logic       H1,
    output logic [4:0] Hour,
    output logic       Chg
);

    localparam int unsigned TickW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam logic [3:0]       DebLast  = 4'(DEB_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_HOUR - 1);
    localparam logic [4:0]       HourLast = 5'd23;
    localparam logic [4:0]       WinStart = 5'(H_START);
    localparam logic [4:0]       WinEnd   = 5'(H_END);

    typedef enum logic {
        StNight,
        StDay
    } win_e;

    // ------------------------------------------------------------------
    // Two-flop synchronisers, one per channel (bit 0 = S5, 1 = S6, 2 = S7)
    // ------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    assign raw = {S7_raw, S6_raw, S5_raw};

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: output flips only after DEB_CYCLES consecutive disagreeing edges
    // ------------------------------------------------------------------
    logic [2:0] deb_q;
    logic [2:0] deb_d;
    logic [3:0] cnt_q [3];
    logic [3:0] cnt_d [3];
    logic       chg_q;
    logic       chg_d;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DebLast) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
        // Registered alongside the flip so the pulse lines up with the new level.
        chg_d = |(deb_d ^ deb_q);
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            deb_q <= '0;
            chg_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            chg_q <= chg_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Time-of-day counter
    // ------------------------------------------------------------------
    logic [TickW-1:0] tick_q;
    logic [TickW-1:0] tick_d;
    logic [4:0]       hour_q;
    logic [4:0]       hour_d;

    always_comb begin
        tick_d = tick_q;
        hour_d = hour_q;
        if (Load) begin
            // Out-of-range presets are dropped and also swallow that cycle's En.
            if (HourIn <= HourLast) begin
                hour_d = HourIn;
                tick_d = '0;
            end
        end else if (En) begin
            if (tick_q == TickLast) begin
                tick_d = '0;
                hour_d = (hour_q == HourLast) ? 5'd0 : hour_q + 5'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            tick_q <= '0;
            hour_q <= '0;
        end else begin
            tick_q <= tick_d;
            hour_q <= hour_d;
        end
    end

    // ------------------------------------------------------------------
    // Day-window FSM, decided from the next hour so H1 moves with Hour
    // ------------------------------------------------------------------
    win_e win_q;
    win_e win_d;
    logic in_window;

    always_comb begin
        in_window = (hour_d >= WinStart) && (hour_d < WinEnd);
        win_d     = win_q;
        unique case (win_q)
            StNight: if (in_window)  win_d = StDay;
            StDay:   if (!in_window) win_d = StNight;
            default: win_d = StNight;
        endcase
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            win_q <= StNight;
        end else begin
            win_q <= win_d;
        end
    end

    assign I5   = deb_q[0];
    assign I6   = deb_q[1];
    assign I7   = deb_q[2];
    assign Chg  = chg_q;
    assign Hour = hour_q;
    assign H1   = (win_q == StDay);

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: table-driven day-counter vectors plus
// hand-written debounce, Chg and reset sequences.
module tb_sensor_conditioner;

    logic       Ck = 1'b0;
    logic       Clr = 1'b0;
    logic       En = 1'b0;
    logic       Load = 1'b0;
    logic [4:0] HourIn = '0;
    logic       S5_raw = 1'b0;
    logic       S6_raw = 1'b0;
    logic       S7_raw = 1'b0;
    logic       I5, I6, I7, H1, Chg;
    logic [4:0] Hour;

    int checks = 0;
    int errors = 0;

    sensor_conditioner #(
        .DEB_CYCLES    (4),
        .TICKS_PER_HOUR(10),
        .H_START       (6),
        .H_END         (18)
    ) dut (
        .Ck    (Ck),
        .Clr   (Clr),
        .En    (En),
        .Load  (Load),
        .HourIn(HourIn),
        .S5_raw(S5_raw),
        .S6_raw(S6_raw),
        .S7_raw(S7_raw),
        .I5    (I5),
        .I6    (I6),
        .I7    (I7),
        .H1    (H1),
        .Hour  (Hour),
        .Chg   (Chg)
    );

    always #5 Ck = ~Ck;

    typedef struct {
        logic       load;
        logic [4:0] hour_in;
        logic       en;
        int         edges;
        logic [4:0] exp_hour;
        logic       exp_h1;
    } hvec_t;

    hvec_t hv [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One rising edge, then settle; inputs are driven from here, away from the edge.
    task automatic step();
        @(posedge Ck);
        #1;
    endtask

    task automatic do_reset();
        #1;
        Clr = 1'b0;
        #1;
        step();
        Clr = 1'b1;
    endtask

    initial begin
        hv[0]  = '{1'b1, 5'd5,  1'b0, 1,  5'd5,  1'b0};
        hv[1]  = '{1'b1, 5'd6,  1'b0, 1,  5'd6,  1'b1};
        hv[2]  = '{1'b1, 5'd17, 1'b0, 1,  5'd17, 1'b1};
        hv[3]  = '{1'b1, 5'd18, 1'b0, 1,  5'd18, 1'b0};
        hv[4]  = '{1'b1, 5'd25, 1'b0, 1,  5'd18, 1'b0};
        hv[5]  = '{1'b1, 5'd24, 1'b1, 1,  5'd18, 1'b0};
        hv[6]  = '{1'b1, 5'd23, 1'b1, 1,  5'd23, 1'b0};
        hv[7]  = '{1'b0, 5'd0,  1'b1, 9,  5'd23, 1'b0};
        hv[8]  = '{1'b0, 5'd0,  1'b1, 1,  5'd0,  1'b0};
        hv[9]  = '{1'b1, 5'd5,  1'b0, 1,  5'd5,  1'b0};
        hv[10] = '{1'b0, 5'd0,  1'b0, 20, 5'd5,  1'b0};
        hv[11] = '{1'b0, 5'd0,  1'b1, 10, 5'd6,  1'b1};
        hv[12] = '{1'b1, 5'd0,  1'b0, 1,  5'd0,  1'b0};

        // Reset held with raw lines toggling
        Clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            S5_raw = i[0];
            S6_raw = i[1];
            S7_raw = ~i[0];
            step();
        end
        chk("rst_outs", {26'd0, I5, I6, I7, H1, Chg}, 32'd0);
        chk("rst_hour", {27'd0, Hour}, 32'd0);
        S5_raw = 1'b0;
        S6_raw = 1'b0;
        S7_raw = 1'b0;
        step();
        step();
        Clr = 1'b1;

        // S7 rise then fall, DEB=4 -> 6 edges each way
        S7_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("s7_rise_i7_e%0d", e), {31'd0, I7}, {31'd0, e >= 6});
            chk($sformatf("s7_rise_chg_e%0d", e), {31'd0, Chg}, {31'd0, e == 6});
        end
        S7_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("s7_fall_i7_e%0d", e), {31'd0, I7}, {31'd0, e < 6});
            chk($sformatf("s7_fall_chg_e%0d", e), {31'd0, Chg}, {31'd0, e == 6});
        end

        // S6 short glitch rejected
        S6_raw = 1'b1;
        step();
        step();
        step();
        S6_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("s6_glitch_e%0d", e), {30'd0, I6, Chg}, 32'd0);
        end

        // 3 high, 1 low, then held high: single rise 6 edges after final rise
        S6_raw = 1'b1;
        step();
        step();
        step();
        S6_raw = 1'b0;
        step();
        S6_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("s6_bounce_i6_e%0d", e), {31'd0, I6}, {31'd0, e >= 6});
            chk($sformatf("s6_bounce_chg_e%0d", e), {31'd0, Chg}, {31'd0, e == 6});
        end
        S6_raw = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        chk("s6_cleared", {31'd0, I6}, 32'd0);

        // S5 and S7 together: same edge, single Chg pulse
        S5_raw = 1'b1;
        S7_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("dual_i5_e%0d", e), {31'd0, I5}, {31'd0, e >= 6});
            chk($sformatf("dual_i7_e%0d", e), {31'd0, I7}, {31'd0, e >= 6});
            chk($sformatf("dual_chg_e%0d", e), {31'd0, Chg}, {31'd0, e == 6});
        end

        // Asynchronous reset mid-run clears outputs before the next edge
        Load = 1'b1;
        HourIn = 5'd10;
        step();
        Load = 1'b0;
        chk("pre_async_h1", {31'd0, H1}, 32'd1);
        #2;
        Clr = 1'b0;
        #1;
        chk("async_outs", {26'd0, I5, I6, I7, H1, Chg}, 32'd0);
        chk("async_hour", {27'd0, Hour}, 32'd0);
        step();
        Clr = 1'b1;
        S5_raw = 1'b0;
        S7_raw = 1'b0;
        for (int e = 1; e <= 3; e++) step();

        // Clr pulsed 3 edges into stable S5 high discards partial count
        S5_raw = 1'b1;
        step();
        step();
        step();
        Clr = 1'b0;
        #1;
        chk("mid_deb_i5", {31'd0, I5}, 32'd0);
        step();
        Clr = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("post_clr_i5_e%0d", e), {31'd0, I5}, {31'd0, e >= 6});
        end
        S5_raw = 1'b0;

        // Free-running day counter from reset
        do_reset();
        En = 1'b1;
        for (int e = 1; e <= 240; e++) begin
            step();
            case (e)
                9:   chk("day_e9_hour",   {27'd0, Hour}, 32'd0);
                10:  chk("day_e10_hour",  {27'd0, Hour}, 32'd1);
                59:  chk("day_e59",       {26'd0, Hour, H1}, {26'd0, 5'd5, 1'b0});
                60:  chk("day_e60",       {26'd0, Hour, H1}, {26'd0, 5'd6, 1'b1});
                179: chk("day_e179",      {26'd0, Hour, H1}, {26'd0, 5'd17, 1'b1});
                180: chk("day_e180",      {26'd0, Hour, H1}, {26'd0, 5'd18, 1'b0});
                239: chk("day_e239_hour", {27'd0, Hour}, 32'd23);
                240: chk("day_e240",      {26'd0, Hour, H1}, {26'd0, 5'd0, 1'b0});
                default: ;
            endcase
        end
        En = 1'b0;

        // Load at tick 5 with En also high: Load wins, tick restarts
        do_reset();
        En = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        Load = 1'b1;
        HourIn = 5'd17;
        step();
        Load = 1'b0;
        chk("load17", {26'd0, Hour, H1}, {26'd0, 5'd17, 1'b1});
        for (int e = 1; e <= 9; e++) step();
        chk("load17_e9", {26'd0, Hour, H1}, {26'd0, 5'd17, 1'b1});
        step();
        chk("load17_e10", {26'd0, Hour, H1}, {26'd0, 5'd18, 1'b0});

        // Illegal preset freezes both Hour and tick for that edge
        for (int e = 1; e <= 3; e++) step();
        Load = 1'b1;
        HourIn = 5'd25;
        step();
        Load = 1'b0;
        chk("load25_hold", {27'd0, Hour}, 32'd18);
        for (int e = 1; e <= 6; e++) step();
        chk("load25_tick_held", {27'd0, Hour}, 32'd18);
        step();
        chk("load25_advance", {27'd0, Hour}, 32'd19);
        En = 1'b0;

        // Table-driven counter vectors
        do_reset();
        for (int v = 0; v < 13; v++) begin
            Load = hv[v].load;
            HourIn = hv[v].hour_in;
            En = hv[v].en;
            for (int e = 0; e < hv[v].edges; e++) begin
                step();
                Load = 1'b0;
            end
            En = 1'b0;
            chk($sformatf("vec%0d_hour", v), {27'd0, Hour}, {27'd0, hv[v].exp_hour});
            chk($sformatf("vec%0d_h1", v), {31'd0, H1}, {31'd0, hv[v].exp_h1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
